// File: rtl/sd_data_rx_deser.sv
// ============================================================================
// Module   : sd_data_rx_deser
// Brief    : SD 4-bit data-bus receive deserializer. It packs nibbles into
//            32-bit FIFO words and checks the per-line CRC16 and the end bit.
//            The CRC16 check is built only when SD_RX_CRC_CHECK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sd_data_rx_deser #(
   parameter int BLOCK_BYTES = 512,
   parameter int TIMEOUT     = 65535
) (
   input  logic        sd_clk,
   input  logic        rst,
   input  logic        start,
   input  logic        abort,
   input  logic [3:0]  dat_pad_i,
   input  logic        full_i,
   output logic [31:0] dat_o,
   output logic        wr_o,
   output logic        busy_o,
   output logic        done_o,
   output logic        crc_ok_o,
   output logic        overrun_o,
   output logic        timeout_o
);

   localparam logic [11:0] C_LAST_NIB = 12'(BLOCK_BYTES * 2 - 1);
   localparam logic [15:0] C_TO_LAST  = 16'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_WAIT_START = 3'd1,
      S_DATA       = 3'd2,
      S_CRC        = 3'd3,
      S_END        = 3'd4,
      S_DONE       = 3'd5
   } state_t;

   state_t      state_q,   state_d;
   logic [11:0] nib_cnt_q, nib_cnt_d;
   logic [3:0]  bit_cnt_q, bit_cnt_d;
   logic [15:0] to_cnt_q,  to_cnt_d;
   logic [27:0] shift_q,   shift_d;
   logic [31:0] dat_q,     dat_d;
   logic        wr_q,      wr_d;
   logic        crc_ok_q,  crc_ok_d;
   logic        overrun_q, overrun_d;
   logic        timeout_q, timeout_d;
   logic        crc_err_q, crc_err_d;
   logic        timeout_hit;

`ifdef SD_RX_CRC_CHECK_EN
   logic [15:0] crc_q [4];
   logic [15:0] crc_d [4];

   // CRC16-CCITT (x^16+x^12+x^5+1), one serial bit, MSB first
   function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic d);
      logic fb;
      fb = d ^ c[15];
      return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
   endfunction
`endif

   assign timeout_hit = (state_q == S_WAIT_START) && (dat_pad_i != 4'b0000) &&
                        (to_cnt_q == C_TO_LAST) && !abort;

   always_comb begin
      state_d   = state_q;
      nib_cnt_d = nib_cnt_q;
      bit_cnt_d = bit_cnt_q;
      to_cnt_d  = to_cnt_q;
      shift_d   = shift_q;
      dat_d     = dat_q;
      wr_d      = 1'b0;
      crc_ok_d  = crc_ok_q;
      overrun_d = overrun_q;
      timeout_d = timeout_q;
      crc_err_d = crc_err_q;
`ifdef SD_RX_CRC_CHECK_EN
      for (int i = 0; i < 4; i++) crc_d[i] = crc_q[i];
`endif

      case (state_q)
         S_IDLE: begin
            nib_cnt_d = '0;
            bit_cnt_d = '0;
            to_cnt_d  = '0;
`ifdef SD_RX_CRC_CHECK_EN
            for (int i = 0; i < 4; i++) crc_d[i] = '0;
`endif
            // Status stays readable after DONE until the next transfer is armed
            if (start) begin
               state_d   = S_WAIT_START;
               overrun_d = 1'b0;
               timeout_d = 1'b0;
               crc_ok_d  = 1'b0;
               crc_err_d = 1'b0;
            end
         end
         S_WAIT_START: begin
            if (dat_pad_i == 4'b0000) begin
               state_d = S_DATA;
            end else if (to_cnt_q == C_TO_LAST) begin
               timeout_d = 1'b1;
               state_d   = S_IDLE;
            end else begin
               to_cnt_d = to_cnt_q + 16'd1;
            end
         end
         S_DATA: begin
            shift_d = {shift_q[23:0], dat_pad_i};
            if (nib_cnt_q[2:0] == 3'd7) begin
               if (full_i) begin
                  overrun_d = 1'b1;
               end else begin
                  wr_d  = 1'b1;
                  dat_d = {shift_q, dat_pad_i};
               end
            end
`ifdef SD_RX_CRC_CHECK_EN
            for (int i = 0; i < 4; i++) crc_d[i] = crc16_step(crc_q[i], dat_pad_i[i]);
`endif
            if (nib_cnt_q == C_LAST_NIB) state_d = S_CRC;
            else                         nib_cnt_d = nib_cnt_q + 12'd1;
         end
         S_CRC: begin
`ifdef SD_RX_CRC_CHECK_EN
            for (int i = 0; i < 4; i++) begin
               if (dat_pad_i[i] != crc_q[i][4'd15 - bit_cnt_q]) crc_err_d = 1'b1;
            end
`endif
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd15) state_d = S_END;
         end
         S_END: begin
            if (dat_pad_i != 4'hF) crc_err_d = 1'b1;
            crc_ok_d = !(crc_err_q || (dat_pad_i != 4'hF));
            state_d  = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Abort wins over everything, including a start in IDLE; sticky flags hold
      if (abort) begin
         state_d   = S_IDLE;
         wr_d      = 1'b0;
         dat_d     = dat_q;
         crc_ok_d  = crc_ok_q;
         overrun_d = overrun_q;
         timeout_d = timeout_q;
         crc_err_d = crc_err_q;
      end
   end

   always_ff @(posedge sd_clk) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         nib_cnt_q <= '0;
         bit_cnt_q <= '0;
         to_cnt_q  <= '0;
         shift_q   <= '0;
         dat_q     <= '0;
         wr_q      <= 1'b0;
         crc_ok_q  <= 1'b0;
         overrun_q <= 1'b0;
         timeout_q <= 1'b0;
         crc_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         nib_cnt_q <= nib_cnt_d;
         bit_cnt_q <= bit_cnt_d;
         to_cnt_q  <= to_cnt_d;
         shift_q   <= shift_d;
         dat_q     <= dat_d;
         wr_q      <= wr_d;
         crc_ok_q  <= crc_ok_d;
         overrun_q <= overrun_d;
         timeout_q <= timeout_d;
         crc_err_q <= crc_err_d;
      end
   end

`ifdef SD_RX_CRC_CHECK_EN
   always_ff @(posedge sd_clk) begin
      if (!rst) begin
         for (int i = 0; i < 4; i++) crc_q[i] <= '0;
      end else begin
         for (int i = 0; i < 4; i++) crc_q[i] <= crc_d[i];
      end
   end
`endif

   assign dat_o     = dat_q;
   assign wr_o      = wr_q;
   assign busy_o    = (state_q != S_IDLE);
   assign done_o    = ((state_q == S_DONE) && !abort) || timeout_hit;
   assign crc_ok_o  = crc_ok_q;
   assign overrun_o = overrun_q;
   assign timeout_o = timeout_q || timeout_hit;

endmodule

`default_nettype wire

// File: tb/tb_sd_data_rx_deser.sv
// ============================================================================
// Module   : tb_sd_data_rx_deser
// Brief    : Self-checking bench for sd_data_rx_deser (word scoreboard + block table)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sd_data_rx_deser;

   localparam int BB = 512;
   localparam int NN = BB * 2;
`ifdef SD_RX_CRC_CHECK_EN
   localparam bit CRC_EN = 1'b1;
`else
   localparam bit CRC_EN = 1'b0;
`endif

   logic        sd_clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [3:0]  dat_pad = 4'hF;
   logic        full = 1'b0;
   logic [31:0] dat_o;
   logic        wr_o, busy_o, done_o, crc_ok_o, overrun_o, timeout_o;

   sd_data_rx_deser #(.BLOCK_BYTES(BB), .TIMEOUT(100)) dut (
      .sd_clk(sd_clk), .rst(rst_n), .start(start), .abort(abort),
      .dat_pad_i(dat_pad), .full_i(full), .dat_o(dat_o), .wr_o(wr_o),
      .busy_o(busy_o), .done_o(done_o), .crc_ok_o(crc_ok_o),
      .overrun_o(overrun_o), .timeout_o(timeout_o)
   );

   always #5 sd_clk = ~sd_clk;

   int          n_vec = 0;
   int          n_err = 0;
   int          wr_cnt = 0;
   int          done_cnt = 0;
   logic        done_ok = 1'b0;
   logic        done_ov = 1'b0;
   logic        prev_wr = 1'b0;
   logic [31:0] exp_q [$];

   typedef struct {
      int kind;       // 0 zeros, 1 random, 2 counting
      int full_word;  // word index completed while full, -1 none
      int flip_line;  // DAT line with one CRC bit flipped, -1 none
      bit bad_end;
      bit start_mid;
      bit exp_ok;
      int exp_wr;
      bit exp_ov;
   } vec_t;

   task automatic tick();
      @(posedge sd_clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] crc_bit(input logic [15:0] c, input logic d);
      logic [15:0] r;
      r = c << 1;
      if (d ^ c[15]) r = r ^ 16'h1021;
      return r;
   endfunction

   // Word scoreboard and done capture, sampled mid-cycle
   initial begin
      logic [31:0] e;
      forever begin
         @(negedge sd_clk);
         if (wr_o) begin
            wr_cnt++;
            n_vec++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL wr_unexpected: dat_o=%h with no word expected", dat_o);
            end else begin
               e = exp_q.pop_front();
               if (dat_o !== e) begin
                  n_err++;
                  $display("FAIL word: got %h expected %h", dat_o, e);
               end
            end
            if (prev_wr) begin
               n_err++;
               $display("FAIL wr_back_to_back: got 1 expected 0");
            end
         end
         prev_wr = wr_o;
         if (done_o) begin
            done_cnt++;
            done_ok = crc_ok_o;
            done_ov = overrun_o;
         end
      end
   end

   task automatic run_block(input vec_t v);
      logic [3:0]  nib [0:NN-1];
      logic [15:0] crc [4];
      logic [31:0] w;
      int wr0, done0;
      for (int i = 0; i < 4; i++) crc[i] = 16'h0;
      for (int j = 0; j < NN; j++) begin
         case (v.kind)
            1:       nib[j] = 4'($urandom);
            2:       nib[j] = 4'(j);
            default: nib[j] = 4'h0;
         endcase
         for (int i = 0; i < 4; i++) crc[i] = crc_bit(crc[i], nib[j][i]);
      end
      wr0 = wr_cnt;
      done0 = done_cnt;
      start = 1'b1; tick(); start = 1'b0;
      dat_pad = 4'hF; tick(); tick();
      dat_pad = 4'h0; tick();
      w = '0;
      for (int j = 0; j < NN; j++) begin
         dat_pad = nib[j];
         w = {w[27:0], nib[j]};
         full = (j % 8 == 7) && (j / 8 == v.full_word);
         start = v.start_mid && (j == 100);
         if ((j % 8 == 7) && !full) exp_q.push_back(w);
         tick();
      end
      full = 1'b0;
      start = 1'b0;
      for (int k = 0; k < 16; k++) begin
         for (int i = 0; i < 4; i++) dat_pad[i] = crc[i][15-k];
         if (k == 3 && v.flip_line >= 0) dat_pad[v.flip_line] = ~dat_pad[v.flip_line];
         tick();
      end
      dat_pad = v.bad_end ? 4'hB : 4'hF; tick();
      dat_pad = 4'hF; tick(); tick();
      chk("blk_done_count", 32'(done_cnt - done0), 32'd1);
      chk("blk_crc_ok",     32'(done_ok), 32'(v.exp_ok));
      chk("blk_overrun",    32'(done_ov), 32'(v.exp_ov));
      chk("blk_wr_count",   32'(wr_cnt - wr0), 32'(v.exp_wr));
      chk("blk_queue_left", 32'(exp_q.size()), 32'd0);
      chk("blk_busy_after", 32'(busy_o), 32'd0);
      chk("blk_timeout",    32'(timeout_o), 32'd0);
   endtask

   initial begin
      vec_t vecs [7];
      int   wr0, done0;
      vecs[0] = '{0, -1, -1, 1'b0, 1'b0, 1'b1,    128, 1'b0};
      vecs[1] = '{1, -1, -1, 1'b0, 1'b0, 1'b1,    128, 1'b0};
      vecs[2] = '{0, -1,  2, 1'b0, 1'b0, !CRC_EN, 128, 1'b0};
      vecs[3] = '{0,  3, -1, 1'b0, 1'b0, 1'b1,    127, 1'b1};
      vecs[4] = '{2, -1, -1, 1'b1, 1'b0, 1'b0,    128, 1'b0};
      vecs[5] = '{1, -1, -1, 1'b0, 1'b1, 1'b1,    128, 1'b0};
      vecs[6] = '{1, -1,  0, 1'b0, 1'b0, !CRC_EN, 128, 1'b0};

      // Reset state
      rst_n = 1'b0; tick(); tick();
      chk("rst_dat_o", dat_o, 32'h0);
      chk("rst_flags", {25'd0, wr_o, busy_o, done_o, crc_ok_o, overrun_o, timeout_o, 1'b0}, 32'h0);
      rst_n = 1'b1; tick();

      // Nibbles 1..8 -> first word 12345678 one cycle after the 8th nibble
      start = 1'b1; tick(); start = 1'b0;
      dat_pad = 4'h0; tick();
      for (int j = 1; j <= 8; j++) begin
         dat_pad = 4'(j);
         if (j == 8) exp_q.push_back(32'h12345678);
         tick();
         if (j == 7) chk("seq_no_early_wr", 32'(wr_o), 32'd0);
      end
      chk("seq_wr", 32'(wr_o), 32'd1);
      chk("seq_word", dat_o, 32'h12345678);
      dat_pad = 4'hF; abort = 1'b1; tick(); abort = 1'b0;
      chk("seq_abort_busy", 32'(busy_o), 32'd0);

      // Timeout with DAT held high
      done0 = done_cnt;
      start = 1'b1; tick(); start = 1'b0;
      dat_pad = 4'hF;
      for (int c = 1; c < 100; c++) begin
         if (c == 99) chk("to_no_early_done", 32'(done_o), 32'd0);
         tick();
      end
      chk("to_done",    32'(done_o), 32'd1);
      chk("to_flag",    32'(timeout_o), 32'd1);
      chk("to_crc_ok",  32'(crc_ok_o), 32'd0);
      chk("to_busy_at", 32'(busy_o), 32'd1);
      tick();
      chk("to_busy_after", 32'(busy_o), 32'd0);
      chk("to_sticky",     32'(timeout_o), 32'd1);
      chk("to_done_once",  32'(done_cnt - done0), 32'd1);

      // Block table
      for (int n = 0; n < 7; n++) run_block(vecs[n]);

      // Abort in DATA cycle 50
      wr0 = wr_cnt;
      done0 = done_cnt;
      start = 1'b1; tick(); start = 1'b0;
      dat_pad = 4'h0; tick();
      begin
         logic [31:0] w;
         w = '0;
         for (int j = 0; j < 49; j++) begin
            dat_pad = 4'($urandom);
            w = {w[27:0], dat_pad};
            if (j % 8 == 7) exp_q.push_back(w);
            tick();
         end
      end
      abort = 1'b1; dat_pad = 4'h5; tick(); abort = 1'b0;
      chk("abort_busy", 32'(busy_o), 32'd0);
      chk("abort_wr",   32'(wr_o), 32'd0);
      for (int j = 0; j < 12; j++) begin dat_pad = 4'($urandom); tick(); end
      dat_pad = 4'hF; tick();
      chk("abort_wr_count", 32'(wr_cnt - wr0), 32'd6);
      chk("abort_no_done",  32'(done_cnt - done0), 32'd0);
      run_block(vecs[0]);

      // Reset mid-transfer: no partial word written
      wr0 = wr_cnt;
      start = 1'b1; tick(); start = 1'b0;
      dat_pad = 4'h0; tick();
      for (int j = 0; j < 12; j++) begin
         dat_pad = 4'(j + 3);
         if (j == 7) exp_q.push_back(32'h3456789A);
         tick();
      end
      rst_n = 1'b0; tick();
      chk("mrst_dat_o", dat_o, 32'h0);
      chk("mrst_flags", {25'd0, wr_o, busy_o, done_o, crc_ok_o, overrun_o, timeout_o, 1'b0}, 32'h0);
      rst_n = 1'b1; dat_pad = 4'hF; tick(); tick(); tick();
      chk("mrst_wr_count", 32'(wr_cnt - wr0), 32'd1);
      chk("mrst_queue",    32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/sd_data_rx_deser.md
Name: sd_data_rx_deser

Overview:
- Receive-side deserializer for the SD 4-bit data bus.
- Runs in the sd_clk domain and sits directly upstream of the RX FIFO filler: it drives that block's dat_i/wr inputs and watches its full output.
- Per armed transfer: waits for the start bit, packs BLOCK_BYTES of nibbles into 32-bit words, pushes them to the FIFO, then checks the per-line CRC16 and the end bit.
- Reports done and status to the data master.

Parameters:
- BLOCK_BYTES, 512, bytes per data block; must be a multiple of 4, range 4..2048.
- TIMEOUT, 65535, sd_clk cycles allowed in WAIT_START before a timeout is declared.

Ports:
- sd_clk  in  1  SD clock; the only clock.
- rst  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse that arms a block receive; honoured only in IDLE.
- abort  in  1  synchronous abort; returns to IDLE next cycle.
- dat_pad_i  in  4  sampled SD DAT[3:0] lines.
- full_i  in  1  RX FIFO full.
- dat_o  out  32  packed data word to the FIFO.
- wr_o  out  1  one-cycle FIFO write strobe.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse at block completion.
- crc_ok_o  out  1  all 4 line CRCs matched and end bit valid; valid when done_o=1, held until next start.
- overrun_o  out  1  sticky: a word was dropped because full_i=1; cleared on start.
- timeout_o  out  1  sticky: no start bit within TIMEOUT cycles; cleared on start.

Behaviour:
- Reset (rst=0 at a sd_clk edge): state IDLE; dat_o=0, wr_o=0, busy_o=0, done_o=0, crc_ok_o=0, overrun_o=0, timeout_o=0; all counters and CRC registers 0.
- States: IDLE, WAIT_START, DATA, CRC, END, DONE.
- IDLE:
  - start=1 -> WAIT_START.
  - Clear overrun_o, timeout_o, crc_ok_o, the CRC registers and the timeout counter.
- WAIT_START:
  - dat_pad_i==4'b0000 -> DATA; the start-bit cycle is not data.
  - Otherwise the counter increments; when it reaches TIMEOUT-1, set timeout_o, pulse done_o with crc_ok_o=0, go IDLE.
- DATA:
  - One nibble per cycle, BLOCK_BYTES*2 cycles. First nibble of each word -> dat_o[31:28], eighth -> dat_o[3:0]; bytes are big-endian within the word.
  - A word completes on the 8th nibble sample; dat_o is updated and wr_o=1 on the next cycle. wr_o is never asserted on two consecutive cycles.
  - If full_i=1 in the cycle a word completes: no wr_o, word discarded, overrun_o set. The transfer continues (the card cannot be stalled mid-block).
  - Each line i feeds its own CRC16 (x^16+x^12+x^5+1, init 0, MSB-first) with dat_pad_i[i] every DATA cycle.
  - After the last nibble -> CRC.
- CRC:
  - 16 cycles; bit k of each line is compared against bit 15-k of that line's CRC register.
  - Any mismatch latches an internal crc_err.
  - After 16 cycles -> END.
- END:
  - One cycle; all lines must be 1, otherwise crc_err is set.
  - -> DONE.
- DONE:
  - done_o=1 for one cycle; crc_ok_o = !crc_err.
  - -> IDLE.
- abort=1 in any state: next state IDLE, wr_o=0, no done_o; sticky flags keep their values. abort takes priority over start.
- start while busy_o=1: ignored.
- rst=0 mid-transfer: all reset values on the next edge; no partial word is written.
- Counters: nibble counter 12 bits, CRC bit counter 4 bits, timeout counter 16 bits, no wrap within a block.

Optional Feature:
- Macro SD_RX_CRC_CHECK_EN.
- Defined: the CRC16 generators and comparison are built as described.
- Undefined: no CRC logic. The CRC state still consumes 16 cycles, ignoring the data; the END bit check remains, so crc_ok_o reflects the end bit only.

Test Plan:
- Block of all zeros, 512 bytes: start -> 128 wr_o pulses, each dat_o=32'h0; CRC bits all 0 -> done_o with crc_ok_o=1, overrun_o=0.
- Nibble sequence 1,2,...,8 after the start bit -> first wr_o carries dat_o=32'h12345678, one cycle after the 8th nibble.
- Zero block with one CRC bit flipped on DAT2 -> done_o with crc_ok_o=1 only when SD_RX_CRC_CHECK_EN is undefined; otherwise crc_ok_o=0.
- full_i=1 while word 3 completes -> 127 wr_o pulses, overrun_o=1, done_o still issued.
- DAT held 4'hF after start, TIMEOUT=100 -> done_o and timeout_o=1 at cycle 100, busy_o=0 the cycle after.
- abort in cycle 50 of DATA -> busy_o=0 next cycle, no further wr_o, no done_o; a new start then completes a clean block normally.
